// File: rtl/pyhdl_if_via_call_arb.sv
// Shares one HDL->Python call channel among N_REQ blocking requesters, round-robin, one call in flight each.
// Latency: call_valid one cycle after the req handshake; done pulse one cycle after the rsp handshake.
// Backpressure: holding register stalls on call_ready=0 (req_ready all low); responses are never backpressured.
//
// Ports:
//   clk_i, rst_n_i             clock, asynchronous active-low reset
//   req_valid_i/req_ready_o    per-requester call handshake, payload slice i of req_data_i
//   call_valid_o/call_ready_i  call to the listener, with call_src_o (granted index) and call_data_o
//   rsp_valid_i/rsp_ready_o    response from the listener, routed by rsp_src_i, payload rsp_data_i
//   done_valid_o/done_data_o   one-cycle per-requester completion pulse and its payload
//   busy_o                     requester has a call outstanding
//   err_unexp_o                sticky: response for a non-busy or out-of-range source
module pyhdl_if_via_call_arb #(
    parameter int N_REQ = 4,
    parameter int DW    = 32,
    parameter int IDW   = 2
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic [N_REQ-1:0]    req_valid_i,
    output logic [N_REQ-1:0]    req_ready_o,
    input  logic [N_REQ*DW-1:0] req_data_i,
    output logic                call_valid_o,
    input  logic                call_ready_i,
    output logic [IDW-1:0]      call_src_o,
    output logic [DW-1:0]       call_data_o,
    input  logic                rsp_valid_i,
    output logic                rsp_ready_o,
    input  logic [IDW-1:0]      rsp_src_i,
    input  logic [DW-1:0]       rsp_data_i,
    output logic [N_REQ-1:0]    done_valid_o,
    output logic [DW-1:0]       done_data_o,
    output logic [N_REQ-1:0]    busy_o,
    output logic                err_unexp_o
);

    logic                call_valid_q;
    logic [IDW-1:0]      call_src_q;
    logic [DW-1:0]       call_data_q;
    logic [N_REQ-1:0]    busy_q, busy_d;
    logic [IDW-1:0]      rr_q, rr_d;
    logic [N_REQ-1:0]    done_valid_q;
    logic [DW-1:0]       done_data_q;
    logic                err_q;
    logic                rsp_ready_q;

    logic [N_REQ-1:0]    eligible;
    logic                gnt_found;
    logic [IDW-1:0]      gnt_idx;
    logic                slot_free;
    logic                accept;
    logic                rsp_hs;
    logic [N_REQ-1:0]    rsp_hit;
    logic                rsp_bad;
    int                  idx;

    // Rotating priority search: start at rr_q, wrap past N_REQ-1 back to 0.
    always_comb begin
        eligible  = req_valid_i & ~busy_q;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        idx       = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(rr_q) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!gnt_found && eligible[idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = IDW'(idx);
            end
        end
    end

    assign slot_free = ~call_valid_q | call_ready_i;
    assign accept    = slot_free & gnt_found;

    always_comb begin
        req_ready_o = '0;
        if (accept) begin
            req_ready_o[gnt_idx] = 1'b1;
        end
    end

    // Match by comparison rather than indexing so out-of-range sources
    // simply hit nothing and fall into the error path.
    assign rsp_hs = rsp_valid_i & rsp_ready_q;
    always_comb begin
        rsp_hit = '0;
        for (int i = 0; i < N_REQ; i++) begin
            rsp_hit[i] = rsp_hs && (rsp_src_i == IDW'(i)) && busy_q[i];
        end
    end
    assign rsp_bad = rsp_hs & ~(|rsp_hit);

    // A response may retire a call still sitting in the holding register;
    // only busy is touched, the call itself still goes out.
    assign busy_d = (busy_q & ~rsp_hit) | req_ready_o;

    always_comb begin
        rr_d = rr_q;
        if (accept) begin
            rr_d = (gnt_idx == IDW'(N_REQ - 1)) ? '0 : gnt_idx + IDW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            call_valid_q <= 1'b0;
            call_src_q   <= '0;
            call_data_q  <= '0;
            busy_q       <= '0;
            rr_q         <= '0;
            done_valid_q <= '0;
            done_data_q  <= '0;
            err_q        <= 1'b0;
            rsp_ready_q  <= 1'b0;
        end else begin
            rsp_ready_q  <= 1'b1;
            busy_q       <= busy_d;
            rr_q         <= rr_d;
            done_valid_q <= rsp_hit;
            if (|rsp_hit) begin
                done_data_q <= rsp_data_i;
            end
            if (rsp_bad) begin
                err_q <= 1'b1;
            end
            if (slot_free) begin
                call_valid_q <= gnt_found;
                if (gnt_found) begin
                    call_src_q  <= gnt_idx;
                    call_data_q <= req_data_i[int'(gnt_idx)*DW +: DW];
                end
            end
        end
    end

    assign call_valid_o = call_valid_q;
    assign call_src_o   = call_src_q;
    assign call_data_o  = call_data_q;
    assign rsp_ready_o  = rsp_ready_q;
    assign done_valid_o = done_valid_q;
    assign done_data_o  = done_data_q;
    assign busy_o       = busy_q;
    assign err_unexp_o  = err_q;

endmodule

// File: tb/tb_pyhdl_if_via_call_arb.sv
// Directed bench for pyhdl_if_via_call_arb (N_REQ=4, DW=32).
// Inputs driven 1 time unit after the rising edge; outputs sampled there too.
// Each scenario task carries its own expected values.
module tb_pyhdl_if_via_call_arb;

    localparam int N_REQ = 4;
    localparam int DW    = 32;
    localparam int IDW   = 2;

    logic                clk;
    logic                rst_n;
    logic [N_REQ-1:0]    req_valid;
    logic [N_REQ-1:0]    req_ready;
    logic [N_REQ*DW-1:0] req_data;
    logic                call_valid;
    logic                call_ready;
    logic [IDW-1:0]      call_src;
    logic [DW-1:0]       call_data;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [IDW-1:0]      rsp_src;
    logic [DW-1:0]       rsp_data;
    logic [N_REQ-1:0]    done_valid;
    logic [DW-1:0]       done_data;
    logic [N_REQ-1:0]    busy;
    logic                err_unexp;

    int vecs = 0;
    int miscmp = 0;

    pyhdl_if_via_call_arb #(.N_REQ(N_REQ), .DW(DW), .IDW(IDW)) dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_data_i   (req_data),
        .call_valid_o (call_valid),
        .call_ready_i (call_ready),
        .call_src_o   (call_src),
        .call_data_o  (call_data),
        .rsp_valid_i  (rsp_valid),
        .rsp_ready_o  (rsp_ready),
        .rsp_src_i    (rsp_src),
        .rsp_data_i   (rsp_data),
        .done_valid_o (done_valid),
        .done_data_o  (done_data),
        .busy_o       (busy),
        .err_unexp_o  (err_unexp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = '0; req_data = '0; call_ready = 1'b0;
        rsp_valid = 1'b0; rsp_src = '0; rsp_data = '0;
        tick(); tick();
        vecs++; if ({call_valid, call_src, call_data, busy, done_valid, done_data, err_unexp, rsp_ready, req_ready} !== '0) begin
            miscmp++; $display("FAIL reset_outputs: got cv=%b src=%0d cd=%h busy=%b dv=%b dd=%h err=%b rr=%b rq=%b, want all 0",
                call_valid, call_src, call_data, busy, done_valid, done_data, err_unexp, rsp_ready, req_ready); end
        rst_n = 1'b1;
        vecs++; if (rsp_ready !== 1'b0) begin miscmp++; $display("FAIL rsp_ready_at_release: got %b want 0", rsp_ready); end
        tick();
        vecs++; if (rsp_ready !== 1'b1) begin miscmp++; $display("FAIL rsp_ready_after_edge: got %b want 1", rsp_ready); end
        vecs++; if ({call_valid, busy, done_valid, err_unexp} !== '0) begin
            miscmp++; $display("FAIL idle_outputs: got cv=%b busy=%b dv=%b err=%b want 0", call_valid, busy, done_valid, err_unexp); end
    endtask

    task automatic test_single();
        req_valid = 4'b0100; req_data[2*DW +: DW] = 32'hA5; call_ready = 1'b1;
        #1;
        vecs++; if (req_ready !== 4'b0100) begin miscmp++; $display("FAIL single_req_ready: got %b want 0100", req_ready); end
        tick();
        req_valid = '0;
        vecs++; if ({call_valid, call_src, call_data, busy} !== {1'b1, 2'd2, 32'hA5, 4'b0100}) begin
            miscmp++; $display("FAIL single_call: got cv=%b src=%0d cd=%h busy=%b want 1/2/a5/0100", call_valid, call_src, call_data, busy); end
        rsp_valid = 1'b1; rsp_src = 2'd2; rsp_data = 32'h5A;
        tick();
        rsp_valid = 1'b0;
        vecs++; if ({done_valid, done_data, busy, call_valid} !== {4'b0100, 32'h5A, 4'b0000, 1'b0}) begin
            miscmp++; $display("FAIL single_done: got dv=%b dd=%h busy=%b cv=%b want 0100/5a/0000/0", done_valid, done_data, busy, call_valid); end
        tick();
        vecs++; if (done_valid !== 4'b0000) begin miscmp++; $display("FAIL single_done_width: got %b want 0000", done_valid); end
    endtask

    task automatic test_round_robin();
        logic [IDW-1:0] exp_src [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        tick();
        rst_n = 1'b0;
        for (int i = 0; i < N_REQ; i++) req_data[i*DW +: DW] = 32'h100 + i;
        req_valid = 4'b1111; call_ready = 1'b1;
        #2 rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            vecs++; if ({call_valid, call_src, call_data} !== {1'b1, exp_src[i], 32'h100 + 32'(exp_src[i])}) begin
                miscmp++; $display("FAIL rr_grant_%0d: got cv=%b src=%0d cd=%h want 1/%0d", i, call_valid, call_src, call_data, exp_src[i]); end
            rsp_valid = 1'b1; rsp_src = exp_src[i]; rsp_data = 32'hD0 + i;
            if (i == 4) req_valid = '0;
            #1;
            vecs++; if ((req_ready & busy) !== 4'b0000) begin
                miscmp++; $display("FAIL rr_busy_regrant_%0d: got req_ready=%b busy=%b want no overlap", i, req_ready, busy); end
        end
        tick();
        rsp_valid = 1'b0;
        vecs++; if ({call_valid, done_valid, done_data, busy} !== {1'b0, 4'b0001, 32'hD4, 4'b0000}) begin
            miscmp++; $display("FAIL rr_drain: got cv=%b dv=%b dd=%h busy=%b want 0/0001/d4/0000", call_valid, done_valid, done_data, busy); end
    endtask

    task automatic test_backpressure();
        req_valid = 4'b1100; req_data[2*DW +: DW] = 32'h22; req_data[3*DW +: DW] = 32'h33; call_ready = 1'b0;
        #1;
        vecs++; if (req_ready !== 4'b0100) begin miscmp++; $display("FAIL bp_first_grant: got %b want 0100", req_ready); end
        tick();
        req_valid = 4'b1000;
        for (int i = 0; i < 5; i++) begin
            tick();
            vecs++; if ({call_valid, call_src, call_data, req_ready} !== {1'b1, 2'd2, 32'h22, 4'b0000}) begin
                miscmp++; $display("FAIL bp_hold_%0d: got cv=%b src=%0d cd=%h rq=%b want 1/2/22/0000", i, call_valid, call_src, call_data, req_ready); end
        end
        call_ready = 1'b1;
        #1;
        vecs++; if (req_ready !== 4'b1000) begin miscmp++; $display("FAIL bp_release_grant: got %b want 1000", req_ready); end
        tick();
        req_valid = '0;
        vecs++; if ({call_valid, call_src, call_data, busy} !== {1'b1, 2'd3, 32'h33, 4'b1100}) begin
            miscmp++; $display("FAIL bp_next_call: got cv=%b src=%0d cd=%h busy=%b want 1/3/33/1100", call_valid, call_src, call_data, busy); end
        rsp_valid = 1'b1; rsp_src = 2'd2; rsp_data = 32'hE2;
        tick();
        rsp_src = 2'd3; rsp_data = 32'hE3;
        tick();
        rsp_valid = 1'b0;
        vecs++; if ({call_valid, done_valid, done_data, busy} !== {1'b0, 4'b1000, 32'hE3, 4'b0000}) begin
            miscmp++; $display("FAIL bp_drain: got cv=%b dv=%b dd=%h busy=%b want 0/1000/e3/0000", call_valid, done_valid, done_data, busy); end
    endtask

    task automatic test_unexpected();
        req_valid = 4'b0001; req_data[0 +: DW] = 32'h77;
        rsp_valid = 1'b1; rsp_src = 2'd1; rsp_data = 32'hBAD;
        tick();
        req_valid = '0; rsp_valid = 1'b0;
        vecs++; if ({err_unexp, done_valid, call_valid, call_src, call_data, busy} !== {1'b1, 4'b0000, 1'b1, 2'd0, 32'h77, 4'b0001}) begin
            miscmp++; $display("FAIL unexp_flag: got err=%b dv=%b cv=%b src=%0d cd=%h busy=%b want 1/0000/1/0/77/0001",
                err_unexp, done_valid, call_valid, call_src, call_data, busy); end
        tick();
        rsp_valid = 1'b1; rsp_src = 2'd0; rsp_data = 32'hC0;
        tick();
        rsp_valid = 1'b0;
        vecs++; if ({err_unexp, done_valid, done_data, busy} !== {1'b1, 4'b0001, 32'hC0, 4'b0000}) begin
            miscmp++; $display("FAIL unexp_sticky: got err=%b dv=%b dd=%h busy=%b want 1/0001/c0/0000", err_unexp, done_valid, done_data, busy); end
    endtask

    task automatic test_fast_path();
        req_valid = 4'b0010; req_data[1*DW +: DW] = 32'h11; call_ready = 1'b0;
        tick();
        req_valid = '0;
        rsp_valid = 1'b1; rsp_src = 2'd1; rsp_data = 32'hF1;
        tick();
        rsp_valid = 1'b0;
        vecs++; if ({call_valid, call_src, busy, done_valid, done_data} !== {1'b1, 2'd1, 4'b0000, 4'b0010, 32'hF1}) begin
            miscmp++; $display("FAIL fast_path: got cv=%b src=%0d busy=%b dv=%b dd=%h want 1/1/0000/0010/f1",
                call_valid, call_src, busy, done_valid, done_data); end
        call_ready = 1'b1;
        tick();
        vecs++; if (call_valid !== 1'b0) begin miscmp++; $display("FAIL fast_path_drain: got cv=%b want 0", call_valid); end
    endtask

    task automatic test_reset_mid();
        req_valid = 4'b1000; req_data[3*DW +: DW] = 32'h3C; call_ready = 1'b0;
        tick();
        req_valid = '0;
        vecs++; if ({busy, call_valid, call_src} !== {4'b1000, 1'b1, 2'd3}) begin
            miscmp++; $display("FAIL mid_setup: got busy=%b cv=%b src=%0d want 1000/1/3", busy, call_valid, call_src); end
        rst_n = 1'b0;
        #1;
        vecs++; if ({busy, call_valid, err_unexp, rsp_ready} !== {4'b0000, 1'b0, 1'b0, 1'b0}) begin
            miscmp++; $display("FAIL mid_reset: got busy=%b cv=%b err=%b rr=%b want 0000/0/0/0", busy, call_valid, err_unexp, rsp_ready); end
        tick();
        rst_n = 1'b1; call_ready = 1'b1;
        tick();
        rsp_valid = 1'b1; rsp_src = 2'd3; rsp_data = 32'h99;
        tick();
        rsp_valid = 1'b0;
        vecs++; if ({err_unexp, done_valid, busy} !== {1'b1, 4'b0000, 4'b0000}) begin
            miscmp++; $display("FAIL mid_late_rsp: got err=%b dv=%b busy=%b want 1/0000/0000", err_unexp, done_valid, busy); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_unexpected();
        test_fast_path();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
        $finish;
    end

endmodule

// File: doc/pyhdl_if_via_call_arb.md
Name: pyhdl_if_via_call_arb

Overview:
- Shares the single HDL→Python call channel feeding the VIA root listener among N HDL-side requesters.
- Requesters are objects, components or transactors issuing blocking calls.
- Round-robin arbitration; at most one outstanding call per requester.
- Responses are routed back by source index and delivered to the requester as a one-cycle done pulse.

Parameters:
- N_REQ, 4, number of requesters (2..16)
- DW, 32, call/response payload width
- IDW, 2, source-index width; must equal clog2(N_REQ), minimum 1

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  N_REQ  per-requester call request
- req_ready  out  N_REQ  per-requester accept
- req_data  in  N_REQ*DW  per-requester payload; slice i = bits [i*DW +: DW]
- call_valid  out  1  call to listener valid
- call_ready  in  1  listener accepts call
- call_src  out  IDW  index of the granted requester
- call_data  out  DW  call payload
- rsp_valid  in  1  response from listener
- rsp_ready  out  1  response accept
- rsp_src  in  IDW  requester index the response targets
- rsp_data  in  DW  response payload
- done_valid  out  N_REQ  one-cycle response-delivered pulse
- done_data  out  DW  response payload, qualified by done_valid
- busy  out  N_REQ  requester has a call outstanding
- err_unexp  out  1  sticky flag: response for a non-busy or out-of-range source

Behaviour:
- Reset (async assert, sync deassert use) clears every register:
  - call_valid=0, call_src=0, call_data=0
  - busy=0, done_valid=0, done_data=0
  - err_unexp=0, rsp_ready=0
  - rr pointer=0
- rsp_ready is registered: 0 in reset, 1 from the first clock edge after reset release. Responses are never backpressured after that.
- Holding register (call_valid/src/data):
  - "slot free" = !call_valid | call_ready.
  - When a request is accepted, the register loads on the same edge.
  - call_valid rises one cycle after the req handshake.
  - Back-to-back calls are sustained at 1 per cycle while call_ready=1.
  - call_src/call_data stay stable while call_valid=1 and call_ready=0.
- Eligible requester i: req_valid[i] & !busy[i] (registered busy).
- Arbitration:
  - Search starts at the rr pointer, increasing index, wrapping at N_REQ-1 → 0.
  - The first eligible requester is granted.
  - req_ready[i] = slot_free & grant[i]; it is combinational from registered state plus req_valid, and at most one bit is set.
  - On accept: busy[i] <= 1 and rr pointer <= (i+1) mod N_REQ.
  - With no accept, the pointer holds.
- Response handling (when rsp_valid & rsp_ready):
  - rsp_src in range and busy[rsp_src]=1:
    - busy clears at the next edge.
    - done_valid[rsp_src]=1 for exactly one cycle (the cycle after the rsp handshake).
    - done_data=rsp_data.
  - Otherwise: the response is dropped, err_unexp <= 1 (sticky until reset), no done pulse.
- A response can arrive while that requester's call is still in the holding register (call_valid=1, not yet accepted). It is treated as valid: busy clears, call_valid is unaffected. This supports listener fast paths.
- Simultaneous accept of requester i and response for requester j≠i in the same cycle: both take effect.
- Response for i and a new req_valid[i] in the same cycle: the new request is not eligible that cycle. It is eligible the cycle after busy clears, so the earliest re-accept is 1 cycle after the rsp handshake.
- Reset mid-operation:
  - All outstanding calls are abandoned; the holding register and busy are cleared.
  - A late response for a pre-reset call sets err_unexp.
- Requesters must hold req_valid/req_data stable until req_ready. The block does not check this.

Test Plan:
- Reset, then idle: rsp_ready=0 → 1 on the first edge; all other outputs 0; err_unexp=0.
- Single call: N_REQ=4, req_valid[2] with data 0xA5, call_ready=1:
  - req_ready[2]=1 that cycle; call_valid=1, call_src=2, call_data=0xA5 next cycle; busy[2]=1.
  - rsp_src=2, rsp_data=0x5A → done_valid[2]=1 for one cycle with done_data=0x5A; busy[2]=0.
- Round-robin: all 4 requesters valid, call_ready=1, responses returned immediately:
  - Grant order is 0,1,2,3,0.
  - A requester is never re-granted while busy; call_valid is continuous while eligible requests exist.
- Backpressure: call_ready=0 for 5 cycles with call_valid=1:
  - call_src/call_data stable; req_ready all 0.
  - call_ready=1 → the next grant is accepted in the same cycle.
- Unexpected response: rsp_valid with rsp_src=1 while busy[1]=0 → err_unexp=1 and stays 1; no done pulse; other traffic unaffected.
- Reset mid-call: busy[3]=1, assert rst_n=0 → busy=0, call_valid=0 immediately. After release, rsp_src=3 → err_unexp=1.
